call_stack_ctrl: RTL and testbench

//  Hardware return-address stack plus pipeline flush sequencer for the 19-bit-instruction core.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/stack_ram.sv | 18 +
 rtl/call_stack_ctrl.sv | 83 ++++++++
 tb/tb_call_stack_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and call-stack FSM state type
package cpu_pkg;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;
  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JSB = 5'b11101;
  localparam logic [5:0] OP_RET = 6'b111100;
  typedef enum logic {IDLE, FLUSH} cs_state_t;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x W register file, one synchronous write port, one asynchronous read port
module stack_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: return-address LIFO plus flush sequencer that opens a bubble window
// after every accepted push/pop/stall event.
module call_stack_ctrl import cpu_pkg::*; #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CW           = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              init_signal,
  input  logic              push,
  input  logic              pop,
  input  logic              stall_req,
  input  logic [ADDR_W-1:0] ret_in,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic              flush,
  output logic [CW-1:0]     depth_cnt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  cs_state_t         r_state, w_next;
  logic [BW-1:0]     r_cnt;
  logic [CW-1:0]     r_depth;
  logic [ADDR_W-1:0] r_ret_addr, w_rd_data;
  logic              r_ret_valid, r_ovf, r_unf;
  logic              w_idle, w_event, w_pop, w_push, w_we;
  logic [PW-1:0]     w_rd_idx;
  assign w_idle      = r_state == IDLE;
  assign w_event     = w_idle && (push || pop || stall_req);
  // pop beats push; a push that loses is silently dropped
  assign w_pop       = w_idle && pop;
  assign w_push      = w_idle && push && !pop;
  assign stack_full  = r_depth == CW'(DEPTH);
  assign stack_empty = r_depth == '0;
  assign w_we        = w_push && !stack_full;
  assign w_rd_idx    = PW'(r_depth - CW'(1));
  stack_ram #(.DEPTH(DEPTH), .W(ADDR_W)) u_ram (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (r_depth[PW-1:0]),
    .i_wdata (ret_in),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = w_event ? FLUSH : IDLE;
    else        w_next = (r_cnt == '0) ? IDLE : FLUSH;
  end
  always_ff @(posedge clock) begin
    if (!init_signal) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_depth     <= '0;
      r_ret_addr  <= '0;
      r_ret_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_event ? BW'(FLUSH_CYCLES - 1) : (w_idle ? r_cnt : r_cnt - 1'b1);
      r_ret_valid <= w_pop;
      if (w_pop) begin
        r_ret_addr <= stack_empty ? '0 : w_rd_data;
        if (!stack_empty) r_depth <= r_depth - 1'b1;
      end
      if (w_we) r_depth <= r_depth + 1'b1;
      if (w_push && stack_full) r_ovf <= 1'b1;
      if (w_pop && stack_empty) r_unf <= 1'b1;
    end
  end
  assign flush     = r_state == FLUSH;
  assign depth_cnt = r_depth;
  assign ret_addr  = r_ret_addr;
  assign ret_valid = r_ret_valid;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: directed table-driven vectors plus hand sequences for fill/drain and reset
module tb_call_stack_ctrl;
  logic        clock = 1'b0;
  logic        init_signal = 1'b0;
  logic        push = 1'b0, pop = 1'b0, stall_req = 1'b0;
  logic [11:0] ret_in = '0;
  logic [11:0] ret_addr;
  logic        ret_valid, flush, stack_full, stack_empty, overflow, underflow;
  logic [3:0]  depth_cnt;
  int n_cmp = 0, n_bad = 0;

  call_stack_ctrl dut (
    .clock(clock), .init_signal(init_signal), .push(push), .pop(pop),
    .stall_req(stall_req), .ret_in(ret_in), .ret_addr(ret_addr),
    .ret_valid(ret_valid), .flush(flush), .depth_cnt(depth_cnt),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pu, po, st;
    logic [11:0] ri;
    logic [11:0] ra;
    logic rv, fl;
    logic [3:0] dc;
    logic fu, em, ov, un;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic pu, logic po, logic st, logic [11:0] ri,
                              logic [11:0] ra, logic rv, logic fl, logic [3:0] dc,
                              logic fu, logic em, logic ov, logic un);
    vec_t v;
    v = '{pu, po, st, ri, ra, rv, fl, dc, fu, em, ov, un};
    return v;
  endfunction

  task automatic step(input logic pu, input logic po, input logic st, input logic [11:0] ri);
    @(negedge clock);
    push = pu; pop = po; stall_req = st; ret_in = ri;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [23:0] obs, exp;
    repeat (2) step(0, 0, 0, 0);
    chk("reset_state", {8'd0, ret_addr, ret_valid, flush, depth_cnt, stack_full, stack_empty, overflow, underflow},
        {8'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clock) init_signal = 1'b1;

    tbl.push_back(mk(1,0,0,12'h123, 12'h000,0,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,0,4'd1,0,0,0,0));
    tbl.push_back(mk(1,0,0,12'h456, 12'h000,0,1,4'd2,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,1,4'd2,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,0,4'd2,0,0,0,0));
    tbl.push_back(mk(0,1,0,12'h000, 12'h456,1,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h456,0,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h456,0,0,4'd1,0,0,0,0));
    tbl.push_back(mk(0,1,0,12'h000, 12'h123,1,1,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h123,0,1,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h123,0,0,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,1,12'h000, 12'h123,0,1,4'd0,0,1,0,0));
    tbl.push_back(mk(1,0,0,12'h777, 12'h123,0,1,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h123,0,0,4'd0,0,1,0,0));
    tbl.push_back(mk(1,0,0,12'h0AB, 12'h123,0,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h123,0,1,4'd1,0,0,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h123,0,0,4'd1,0,0,0,0));
    tbl.push_back(mk(1,1,0,12'h155, 12'h0AB,1,1,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h0AB,0,1,4'd0,0,1,0,0));
    tbl.push_back(mk(0,0,0,12'h000, 12'h0AB,0,0,4'd0,0,1,0,0));
    tbl.push_back(mk(0,1,0,12'h000, 12'h000,1,1,4'd0,0,1,0,1));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,1,4'd0,0,1,0,1));
    tbl.push_back(mk(0,0,0,12'h000, 12'h000,0,0,4'd0,0,1,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].pu, tbl[i].po, tbl[i].st, tbl[i].ri);
      obs = {ret_addr, ret_valid, flush, depth_cnt, stack_full, stack_empty, overflow, underflow};
      exp = {tbl[i].ra, tbl[i].rv, tbl[i].fl, tbl[i].dc, tbl[i].fu, tbl[i].em, tbl[i].ov, tbl[i].un};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got ra=%h rv=%b fl=%b dc=%0d fu=%b em=%b ov=%b un=%b expected ra=%h rv=%b fl=%b dc=%0d fu=%b em=%b ov=%b un=%b",
                 i, ret_addr, ret_valid, flush, depth_cnt, stack_full, stack_empty, overflow, underflow,
                 tbl[i].ra, tbl[i].rv, tbl[i].fl, tbl[i].dc, tbl[i].fu, tbl[i].em, tbl[i].ov, tbl[i].un);
      end
    end

    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 12'h010 + 12'(i));
      chk($sformatf("fill_depth%0d", i), 32'(depth_cnt), (i < 8) ? i + 1 : 8);
      chk($sformatf("fill_ovf%0d", i), 32'(overflow), (i == 8) ? 1 : 0);
      repeat (2) step(0, 0, 0, 0);
    end
    chk("fill_full", 32'(stack_full), 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      chk($sformatf("drain_addr%0d", i), {19'd0, ret_valid, ret_addr}, {19'd0, 1'b1, 12'h017 - 12'(i)});
      chk($sformatf("drain_depth%0d", i), 32'(depth_cnt), 7 - i);
      repeat (2) step(0, 0, 0, 0);
    end
    chk("drain_empty", 32'(stack_empty), 1);

    step(1, 0, 0, 12'h3FF);
    chk("pre_reset_flush", 32'(flush), 1);
    @(negedge clock) init_signal = 1'b0;
    repeat (3) step(0, 0, 0, 0);
    chk("reset_mid_flush", {25'd0, ret_valid, flush, depth_cnt, overflow, underflow},
        {25'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    @(negedge clock) init_signal = 1'b1;
    step(0, 0, 0, 0);
    chk("post_reset_idle", {28'd0, ret_valid, flush, stack_empty, overflow},
        {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
